// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared types and constants for the SPI transfer sequencer and its neighbours.
package spi_xfer_sequencer_pkg;

    localparam int SPI_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_LOAD  = 3'd1,
        SEQ_START = 3'd2,
        SEQ_WAIT  = 3'd3,
        SEQ_STORE = 3'd4,
        SEQ_GAP   = 3'd5
    } seq_state_e;

    // Bundle seen by the shift-clock control block.
    typedef struct packed {
        logic                      shift_load;
        logic                      shift_start;
        logic [SPI_DATA_WIDTH-1:0] shift_tx_data;
    } sc_seq_t;

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// FIFO and shifter handshake bundle; master = sequencer side, slave = FIFO/shifter side.
interface spi_xfer_sequencer_if
    import spi_xfer_sequencer_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_WIDTH
);
    logic              tfifo_empty;
    logic [DATA_W-1:0] tfifo_rdata;
    logic              tfifo_rd;
    logic              rfifo_full;
    logic              rfifo_wr;
    logic [DATA_W-1:0] rfifo_wdata;
    logic              shift_load;
    logic [DATA_W-1:0] shift_tx_data;
    logic              shift_start;
    logic [DATA_W-1:0] shift_rx_data;
    logic              transfer_complete;

    modport master (
        input  tfifo_empty, tfifo_rdata, rfifo_full, shift_rx_data, transfer_complete,
        output tfifo_rd, rfifo_wr, rfifo_wdata, shift_load, shift_tx_data, shift_start
    );

    modport slave (
        output tfifo_empty, tfifo_rdata, rfifo_full, shift_rx_data, transfer_complete,
        input  tfifo_rd, rfifo_wr, rfifo_wdata, shift_load, shift_tx_data, shift_start
    );
endinterface

// File: rtl/spi_xfer_sequencer_sync3.sv
// Three-flop synchronizer with rising-edge detect for a level from another clock domain.
module spi_xfer_sequencer_sync3 (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic async_in,
    output logic rise
);
    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else if (clr) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= async_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_3;
endmodule

// File: rtl/spi_xfer_sequencer.sv
// Moves words between the TX/RX FIFOs and the SPI shifter, one frame at a time.
//   state | meaning
//   IDLE  | waiting for TX data (master) or a completed frame (slave)
//   LOAD  | pop TX word, load shifter, latch frame length
//   START | one-cycle start pulse to shift-clock control
//   WAIT  | frame in flight, timeout down-counter running
//   STORE | push RX word or flag overrun
//   GAP   | master inter-frame idle with ss_n high
module spi_xfer_sequencer
    import spi_xfer_sequencer_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_WIDTH,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spie,
    input  logic                 mstr,
    input  logic                 talk,
    input  logic [4:0]           data_len,
    spi_xfer_sequencer_if.master bus,
    output logic                 ss_n,
    output logic                 busy,
    output logic                 rx_overrun,
    output logic                 timeout
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    localparam logic [2:0] ST_IDLE  = SEQ_IDLE;
    localparam logic [2:0] ST_LOAD  = SEQ_LOAD;
    localparam logic [2:0] ST_START = SEQ_START;
    localparam logic [2:0] ST_WAIT  = SEQ_WAIT;
    localparam logic [2:0] ST_STORE = SEQ_STORE;
    localparam logic [2:0] ST_GAP   = SEQ_GAP;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [4:0]       len_q;
    logic             mstr_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             done_edge;
    logic             in_load;
    logic             in_store;
    logic             tmo_hit;

    // Double shift keeps len=31 from overflowing the shift amount: all DATA_W bits survive.
    function automatic logic [DATA_W-1:0] len_mask(input logic [4:0] len);
        return ~(({DATA_W{1'b1}} << len) << 1);
    endfunction

    spi_xfer_sequencer_sync3 u_sync (
        .clk      (clk),
        .rst      (rst),
        .clr      (~spie),
        .async_in (bus.transfer_complete),
        .rise     (done_edge)
    );

    always_comb begin
        state_d = state_q;
        if (!spie) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mstr) begin
                        if (talk ? !bus.tfifo_empty : !bus.rfifo_full) state_d = ST_LOAD;
                    end else if (done_edge) begin
                        state_d = ST_STORE;
                    end
                end
                ST_LOAD:  state_d = ST_START;
                ST_START: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (done_edge)             state_d = ST_STORE;
                    else if (tmo_cnt_q == '0)  state_d = ST_IDLE;
                end
                ST_STORE: state_d = mstr_q ? ST_GAP : ST_IDLE;
                ST_GAP:   if (gap_cnt_q == '0) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Length and mode are sampled up to the end of LOAD (mode only in IDLE), frozen for the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            mstr_q    <= 1'b0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (!spie) begin
                tmo_cnt_q <= '0;
                gap_cnt_q <= '0;
            end else begin
                if (state_q == ST_IDLE || state_q == ST_LOAD) len_q <= data_len;
                if (state_q == ST_IDLE) mstr_q <= mstr;
                if (state_q == ST_START)
                    tmo_cnt_q <= TMO_LOAD;
                else if (state_q == ST_WAIT && tmo_cnt_q != '0)
                    tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
                if (state_q == ST_STORE)
                    gap_cnt_q <= GAP_LOAD;
                else if (state_q == ST_GAP && gap_cnt_q != '0)
                    gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
        end
    end

    assign in_load  = spie && (state_q == ST_LOAD);
    assign in_store = spie && (state_q == ST_STORE);
    assign tmo_hit  = spie && (state_q == ST_WAIT) && !done_edge && (tmo_cnt_q == '0);

    assign bus.shift_load    = in_load;
    assign bus.tfifo_rd      = in_load && talk;
    assign bus.shift_tx_data = (in_load && talk) ? (bus.tfifo_rdata & len_mask(data_len)) : '0;
    assign bus.shift_start   = spie && (state_q == ST_START);
    assign bus.rfifo_wr      = in_store && !bus.rfifo_full;
    assign bus.rfifo_wdata   = (in_store && !bus.rfifo_full) ?
                               (bus.shift_rx_data & len_mask(len_q)) : '0;

    assign rx_overrun = in_store && bus.rfifo_full;
    assign timeout    = tmo_hit;
    assign busy       = (state_q != ST_IDLE);
    assign ss_n       = !(spie && !tmo_hit &&
                          (state_q == ST_LOAD || state_q == ST_START || state_q == ST_WAIT));
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a queue scoreboard on shifter loads and RX pushes.
module tb_spi_xfer_sequencer;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 16;

    logic       clk;
    logic       rst;
    logic       spie;
    logic       mstr;
    logic       talk;
    logic [4:0] data_len;
    logic       ss_n;
    logic       busy;
    logic       rx_overrun;
    logic       timeout;

    spi_xfer_sequencer_if #(.DATA_W(32)) bus ();

    spi_xfer_sequencer #(
        .DATA_W      (32),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spie       (spie),
        .mstr       (mstr),
        .talk       (talk),
        .data_len   (data_len),
        .bus        (bus),
        .ss_n       (ss_n),
        .busy       (busy),
        .rx_overrun (rx_overrun),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_rd = 0, n_wr = 0, n_ovr = 0, n_tmo = 0, n_ssn_low = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.tfifo_rd) n_rd++;
                if (rx_overrun) n_ovr++;
                if (timeout) n_tmo++;
                if (!ss_n) n_ssn_low++;
                if (bus.shift_load) begin
                    if (tx_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_load: shift_tx_data=0x%08h, none expected",
                                 bus.shift_tx_data);
                    end else check("shift_tx_data", bus.shift_tx_data, tx_q.pop_front());
                end
                if (bus.rfifo_wr) begin
                    n_wr++;
                    if (rx_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_push: rfifo_wdata=0x%08h, none expected",
                                 bus.rfifo_wdata);
                    end else check("rfifo_wdata", bus.rfifo_wdata, rx_q.pop_front());
                end
            end
        end
    endtask

    function automatic bit cond_hit(input int kind);
        case (kind)
            0:       return bus.tfifo_rd;
            1:       return bus.shift_start;
            2:       return bus.rfifo_wr | rx_overrun;
            3:       return timeout;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_neg(input string what, input int kind, input int budget, output int cyc);
        bit hit = 0;
        cyc = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            cyc = i + 1;
            hit = cond_hit(kind);
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL wait_%s: got no event expected one within %0d cycles", what, budget);
        end
    endtask

    task automatic master_frame(input string tag, input logic [31:0] tx, input logic [31:0] exp_tx,
                                input logic [31:0] rx, input logic [31:0] exp_rx,
                                input bit full_at_store, input logic [4:0] len_after);
        int cyc;
        int g;
        int ovr0;
        bit gap_ssn_ok;
        ovr0 = n_ovr;
        tx_q.push_back(exp_tx);
        if (!full_at_store) rx_q.push_back(exp_rx);
        @(posedge clk); #1;
        bus.tfifo_rdata = tx;
        bus.tfifo_empty = 1'b0;
        wait_neg({tag, "_pop"}, 0, 20, cyc);
        @(posedge clk); #1;
        bus.tfifo_empty = 1'b1;
        data_len = len_after;
        if (full_at_store) bus.rfifo_full = 1'b1;
        wait_neg({tag, "_start"}, 1, 20, cyc);
        check({tag, "_ss_n_active"}, 32'(ss_n), 32'd0);
        @(posedge clk); #1;
        bus.shift_rx_data = rx;
        bus.transfer_complete = 1'b1;
        wait_neg({tag, "_store"}, 2, 20, cyc);
        @(posedge clk); #1;
        bus.transfer_complete = 1'b0;
        bus.rfifo_full = 1'b0;
        g = 0;
        gap_ssn_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (ss_n !== 1'b1) gap_ssn_ok = 1'b0;
            g++;
        end
        check({tag, "_gap_cycles"}, 32'(g), 32'(GAP_CYC));
        check({tag, "_gap_ss_n"}, 32'(gap_ssn_ok), 32'd1);
        check({tag, "_overrun_cnt"}, 32'(n_ovr - ovr0), full_at_store ? 32'd1 : 32'd0);
    endtask

    initial begin
        int cyc;
        int base_wr;
        int base_rd;
        int base_ssn;
        int base_tmo;
        fork
            monitor();
        join_none

        rst = 1'b1; spie = 1'b0; mstr = 1'b0; talk = 1'b0; data_len = 5'd0;
        bus.tfifo_empty = 1'b1; bus.tfifo_rdata = '0; bus.rfifo_full = 1'b0;
        bus.shift_rx_data = '0; bus.transfer_complete = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ss_n", 32'(ss_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tfifo_rd", 32'(bus.tfifo_rd), 32'd0);
        check("rst_rfifo_wr", 32'(bus.rfifo_wr), 32'd0);
        check("rst_shift_tx_data", bus.shift_tx_data, 32'd0);
        check("rst_rfifo_wdata", bus.rfifo_wdata, 32'd0);
        check("rst_pulses", {30'd0, timeout, rx_overrun}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; spie = 1'b1; mstr = 1'b1; talk = 1'b1;

        data_len = 5'd7;
        master_frame("len7", 32'hA5A5_12C3, 32'h0000_00C3, 32'h0000_01FF, 32'h0000_00FF, 0, 5'd7);
        data_len = 5'd31;
        master_frame("len31", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8765_4321, 32'h8765_4321, 0, 5'd31);
        data_len = 5'd15;
        master_frame("len15_cfgchg", 32'h1234_ABCD, 32'h0000_ABCD, 32'hFFFF_0F0F, 32'h0000_0F0F,
                     0, 5'd3);
        data_len = 5'd0;
        master_frame("len0", 32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 0, 5'd0);
        data_len = 5'd7;
        master_frame("overrun", 32'h0000_0055, 32'h0000_0055, 32'h0000_0077, 32'h0, 1, 5'd7);

        // Timeout: shifter never reports completion.
        base_tmo = n_tmo;
        tx_q.push_back(32'h0000_00AA);
        @(posedge clk); #1;
        bus.tfifo_rdata = 32'h00FF_00AA;
        bus.tfifo_empty = 1'b0;
        wait_neg("tmo_pop", 0, 20, cyc);
        @(posedge clk); #1;
        bus.tfifo_empty = 1'b1;
        wait_neg("tmo_start", 1, 20, cyc);
        wait_neg("tmo_pulse", 3, 40, cyc);
        check("tmo_wait_cycles", 32'(cyc), 32'(TIMEOUT_CYC));
        check("tmo_ss_n", 32'(ss_n), 32'd1);
        @(negedge clk);
        check("tmo_busy_after", 32'(busy), 32'd0);
        check("tmo_pulse_cnt", 32'(n_tmo - base_tmo), 32'd1);

        // spie dropped mid-frame.
        base_wr = n_wr;
        tx_q.push_back(32'h0000_0034);
        @(posedge clk); #1;
        bus.tfifo_rdata = 32'h0000_1234;
        bus.tfifo_empty = 1'b0;
        wait_neg("spie_pop", 0, 20, cyc);
        @(posedge clk); #1;
        bus.tfifo_empty = 1'b1;
        wait_neg("spie_start", 1, 20, cyc);
        @(posedge clk); #1;
        spie = 1'b0;
        @(negedge clk);
        check("spie_off_ss_n", 32'(ss_n), 32'd1);
        @(negedge clk);
        check("spie_off_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        bus.shift_rx_data = 32'h0000_00EE;
        bus.transfer_complete = 1'b1;
        repeat (3) @(posedge clk); #1;
        bus.transfer_complete = 1'b0;
        spie = 1'b1;
        repeat (2) @(posedge clk); #1;
        bus.transfer_complete = 1'b1;
        repeat (3) @(posedge clk); #1;
        bus.transfer_complete = 1'b0;
        repeat (8) @(negedge clk);
        check("spie_no_push", 32'(n_wr - base_wr), 32'd0);
        check("spie_idle", 32'(busy), 32'd0);

        // Slave, receive-only: three frames captured, no pops, ss_n stays high.
        @(posedge clk); #1;
        mstr = 1'b0; talk = 1'b0; data_len = 5'd11;
        bus.tfifo_empty = 1'b0; bus.tfifo_rdata = 32'h0000_DEAD;
        base_wr = n_wr; base_rd = n_rd; base_ssn = n_ssn_low;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] rxv;
            case (k)
                0:       rxv = 32'h000A_BCDE;
                1:       rxv = 32'hFFFF_FFFF;
                default: rxv = 32'h0000_0800;
            endcase
            rx_q.push_back(rxv & 32'h0000_0FFF);
            bus.shift_rx_data = rxv;
            bus.transfer_complete = 1'b1;
            repeat (3) @(posedge clk); #1;
            bus.transfer_complete = 1'b0;
            repeat (6) @(posedge clk); #1;
        end
        check("slave_pushes", 32'(n_wr - base_wr), 32'd3);
        check("slave_no_pop", 32'(n_rd - base_rd), 32'd0);
        check("slave_ss_n_high", 32'(n_ssn_low - base_ssn), 32'd0);

        repeat (2) @(negedge clk);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
